test_monitor: RTL and testbench
===============================

# test_monitor

Synthesizable self-check monitor for CPU-level test programs. It watches the instruction fetch stream (`i_read`, `pc`) of `module_top` and produces a sticky verdict: PASS or FAIL on configurable signature words, TIMEOUT after a cycle budget, or BREAK on one of several PC breakpoints, with resume support. It sits beside the CPU in simulation and FPGA top levels, and replaces ad-hoc testbench checks with one block that works in both.

## Interface
- `XLEN`, 32, width of fetch word and PC
- `PASS_WORD`, 32'h0000_0001, fetched word signalling test pass
- `FAIL_WORD`, 32'h0000_0000, fetched word signalling test fail
- `TIMEOUT_CYCLES`, 50000, RUN-cycle budget before TIMEOUT (≥1)
- `ARM_DELAY`, 4, cycles after reset/clear during which fetches are ignored (≥0)
- `BP_COUNT`, 2, number of PC breakpoints (≥1)
- `CNT_W`, $clog2(TIMEOUT_CYCLES+1), cycle counter width
- `BP_IDX_W`, (BP_COUNT>1) ? $clog2(BP_COUNT) : 1

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — asynchronous, active-low
- `i_valid` in 1 — `i_read`/`pc` carry a valid fetch this cycle
- `i_read` in XLEN — fetched instruction word
- `pc` in XLEN — address of fetched word
- `bp_addr` in BP_COUNT*XLEN — breakpoint k at bits [k*XLEN +: XLEN]
- `bp_en` in BP_COUNT — per-breakpoint enable
- `clear` in 1 — synchronous restart pulse
- `resume` in 1 — leave BREAK, continue counting
- `done` out 1 — verdict is terminal (PASS/FAIL/TIMEOUT)
- `verdict` out 3 — 0 RUNNING, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 BREAK
- `cycle_count` out CNT_W — RUN cycles elapsed
- `event_pc` out XLEN — `pc` captured at the last PASS/FAIL/BREAK event
- `bp_idx` out BP_IDX_W — index of the breakpoint that caused BREAK

## Operation
- States: ARM, RUN, BREAK, PASS, FAIL, TIMEOUT. `verdict` = 0 in ARM/RUN.
- Reset (async, `reset`=0): state ARM (RUN if ARM_DELAY=0), arm counter 0, `cycle_count` 0, `event_pc` 0, `bp_idx` 0, `done` 0, `verdict` 0, resume mask cleared.
- ARM: count ARM_DELAY cycles, ignoring all fetches, then RUN.
- RUN: `cycle_count` += 1 per cycle. Events are qualified by `i_valid`. Priority when several occur on one cycle: FAIL (`i_read`==FAIL_WORD) > PASS (`i_read`==PASS_WORD) > BREAK > TIMEOUT. If PASS_WORD == FAIL_WORD, the match is FAIL.
- Breakpoint k matches when `bp_en[k]` and `pc`==bp k. The lowest matching index wins and is captured in `bp_idx`.
- TIMEOUT is taken when `cycle_count`==TIMEOUT_CYCLES-1 and no higher-priority event occurs.
- On a PASS/FAIL/BREAK event, `event_pc` takes `pc`.
- BREAK: `cycle_count` holds. `resume` returns the monitor to RUN. After resume, breakpoint matches are masked while `pc` equals the captured `event_pc`. The mask clears on the first valid fetch with a different `pc`. PASS/FAIL matching stays active in RUN regardless of the mask.
- PASS/FAIL/TIMEOUT are sticky. `resume` is ignored in these states. `cycle_count` holds.
- `clear` from any state returns the monitor to ARM with the reset values, except `event_pc` and `bp_idx`, which are cleared too. `clear` overrides any simultaneous event or `resume`.
- `cycle_count` saturates at its maximum value; it never wraps.
- Unknown (X/Z) fetch words must not match. Matches use `==` on `i_valid`-qualified data, and the bench drives `i_valid`=0 during undefined fetches.

## Timing
- The event is sampled on edge N and `verdict`/`done`/`event_pc` update on edge N. They are visible in the cycle after the fetch. Latency is 1 cycle.
- TIMEOUT: `verdict`=3 is visible exactly TIMEOUT_CYCLES cycles after the ARM→RUN edge, with no valid events in between.
- `resume` sampled on edge N gives RUN from N. Counting resumes at edge N+1.
- `clear` sampled on edge N gives ARM. First RUN edge is N+ARM_DELAY+1.
- The async reset assert is immediate. Deassertion must be synchronized externally; the first counted edge follows it.

## Configuration
- `TEST_MONITOR_BP_EN`: when defined, breakpoint logic, the BREAK state, `resume` handling and the resume mask are compiled in.
- When undefined, the `bp_addr`/`bp_en`/`resume` ports remain but are ignored. BREAK is unreachable, `bp_idx` is constant 0, and `verdict` never shows 4.

## Test plan
- ARM_DELAY=4, `i_read`=0 with `i_valid`=1 from reset onward → no FAIL during the 4 ARM cycles. `verdict`=2 one cycle after the first RUN fetch.
- In RUN, fetch `i_read`=32'h1 at `pc`=32'h0000_00A4 → `verdict`=1, `done`=1, `event_pc`=32'hA4. The verdict holds through further fetches of 0.
- TIMEOUT_CYCLES=10 with no events → `verdict`=3 exactly 10 cycles after entering RUN. `cycle_count`=9 and holds.
- BP0=32'h40 and BP1=32'h40, both enabled, fetch `pc`=32'h40 → BREAK, `bp_idx`=0, count holds. Pulse `resume` with `pc` still 32'h40 → stays RUN. Fetch 32'h44 and then 32'h40 → BREAK again.
- One fetch with `i_read`=FAIL_WORD, `pc`=BP0 and `cycle_count`=TIMEOUT_CYCLES-1 → `verdict`=2. Repeat with `clear` asserted on that cycle → ARM, `verdict`=0, `cycle_count`=0.
- Build without `TEST_MONITOR_BP_EN`, hit BP0 → no BREAK, count continues. Assert `reset` low mid-RUN → all outputs return to 0 immediately.

Source files
------------

// File: rtl/test_monitor_if.sv
// test_monitor_if: instruction fetch stream observed by test_monitor.
// master drives the fetch, slave only watches it.
interface test_monitor_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [XLEN-1:0] i_read;
  logic [XLEN-1:0] pc;

  modport master (output i_valid, i_read, pc);
  modport slave  (input  i_valid, i_read, pc);
endinterface

// File: rtl/test_monitor.sv
// test_monitor: sticky PASS/FAIL/TIMEOUT/BREAK verdict on a fetch stream.
// Define TEST_MONITOR_BP_EN to build breakpoints, BREAK and resume.
module test_monitor #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] PASS_WORD      = 32'h0000_0001,
  parameter logic [XLEN-1:0] FAIL_WORD      = 32'h0000_0000,
  parameter int              TIMEOUT_CYCLES = 50000,
  parameter int              ARM_DELAY      = 4,
  parameter int              BP_COUNT       = 2,
  parameter int              CNT_W          = $clog2(TIMEOUT_CYCLES+1),
  parameter int              BP_IDX_W       =
    (BP_COUNT > 1) ? $clog2(BP_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  test_monitor_if.slave            fetch,
  input  logic [BP_COUNT*XLEN-1:0] bp_addr,
  input  logic [BP_COUNT-1:0]      bp_en,
  input  logic                     clear,
  input  logic                     resume,
  output logic                     done,
  output logic [2:0]               verdict,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [XLEN-1:0]          event_pc,
  output logic [BP_IDX_W-1:0]      bp_idx
);

  typedef enum logic [2:0] {
    S_ARM, S_RUN, S_BREAK, S_PASS, S_FAIL, S_TIMEOUT
  } state_t;

  localparam logic [2:0] V_RUN   = 3'd0;
  localparam logic [2:0] V_PASS  = 3'd1;
  localparam logic [2:0] V_FAIL  = 3'd2;
  localparam logic [2:0] V_TOUT  = 3'd3;
  localparam logic [2:0] V_BREAK = 3'd4;

  localparam int AW = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
  localparam logic [AW-1:0] ARM_LAST =
    AW'((ARM_DELAY > 0) ? ARM_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam state_t START = (ARM_DELAY == 0) ? S_RUN : S_ARM;

  state_t              state;
  logic [AW-1:0]       arm_cnt;
  logic                fail_hit;
  logic                pass_hit;
  logic                bp_hit;
  logic                to_hit;
  logic [BP_IDX_W-1:0] bp_sel;

  assign fail_hit = fetch.i_valid && (fetch.i_read == FAIL_WORD);
  assign pass_hit = fetch.i_valid && (fetch.i_read == PASS_WORD);
  assign to_hit   = (cycle_count == CNT_LAST);

`ifdef TEST_MONITOR_BP_EN
  logic                mask;
  logic [BP_COUNT-1:0] bp_match;

  always_comb begin
    bp_match = '0;
    for (int k = 0; k < BP_COUNT; k++)
      bp_match[k] = bp_en[k] &&
        (fetch.pc == bp_addr[k*XLEN +: XLEN]);
  end

  // lowest matching index wins
  always_comb begin
    bp_sel = '0;
    for (int k = BP_COUNT - 1; k >= 0; k--)
      if (bp_match[k]) bp_sel = BP_IDX_W'(k);
  end

  // after resume, the breakpoint we stopped on stays quiet until pc moves
  assign bp_hit = fetch.i_valid && (|bp_match) &&
    !(mask && (fetch.pc == event_pc));
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_en, resume};
  assign bp_sel    = '0;
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= START;
      arm_cnt     <= '0;
      cycle_count <= '0;
      event_pc    <= '0;
      bp_idx      <= '0;
      done        <= 1'b0;
      verdict     <= V_RUN;
`ifdef TEST_MONITOR_BP_EN
      mask        <= 1'b0;
`endif
    end else if (clear) begin
      state       <= START;
      arm_cnt     <= '0;
      cycle_count <= '0;
      event_pc    <= '0;
      bp_idx      <= '0;
      done        <= 1'b0;
      verdict     <= V_RUN;
`ifdef TEST_MONITOR_BP_EN
      mask        <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_ARM: begin
          if (arm_cnt == ARM_LAST) state <= S_RUN;
          else arm_cnt <= arm_cnt + 1'b1;
        end
        S_RUN: begin
`ifdef TEST_MONITOR_BP_EN
          if (fetch.i_valid && (fetch.pc != event_pc))
            mask <= 1'b0;
`endif
          if (fail_hit) begin
            state    <= S_FAIL;
            verdict  <= V_FAIL;
            done     <= 1'b1;
            event_pc <= fetch.pc;
          end else if (pass_hit) begin
            state    <= S_PASS;
            verdict  <= V_PASS;
            done     <= 1'b1;
            event_pc <= fetch.pc;
          end else if (bp_hit) begin
            state    <= S_BREAK;
            verdict  <= V_BREAK;
            event_pc <= fetch.pc;
            bp_idx   <= bp_sel;
          end else if (to_hit) begin
            state   <= S_TIMEOUT;
            verdict <= V_TOUT;
            done    <= 1'b1;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
`ifdef TEST_MONITOR_BP_EN
        S_BREAK: begin
          if (resume) begin
            state   <= S_RUN;
            verdict <= V_RUN;
            mask    <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed scoreboard bench for test_monitor.
// Stimulus queues expected outputs; a negedge monitor compares them.
module tb_test_monitor;

  localparam int XLEN = 32;
  localparam int TO   = 10;
  localparam int CW   = $clog2(TO + 1);

`ifdef TEST_MONITOR_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  typedef struct {
    string       name;
    int          v;
    int          d;
    int          cnt;
    logic [31:0] epc;
    int          idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*XLEN-1:0] bp_addr;
  logic [1:0]        bp_en;
  logic              clear;
  logic              resume;
  logic              done;
  logic [2:0]        verdict;
  logic [CW-1:0]     cycle_count;
  logic [XLEN-1:0]   event_pc;
  logic [0:0]        bp_idx;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  test_monitor_if #(.XLEN(XLEN)) fif();

  test_monitor #(
    .XLEN(XLEN),
    .TIMEOUT_CYCLES(TO),
    .ARM_DELAY(4),
    .BP_COUNT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch(fif),
    .bp_addr(bp_addr),
    .bp_en(bp_en),
    .clear(clear),
    .resume(resume),
    .done(done),
    .verdict(verdict),
    .cycle_count(cycle_count),
    .event_pc(event_pc),
    .bp_idx(bp_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0h expected=%0h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "verdict", 32'(verdict), e.v);
      chk(e.name, "done", 32'(done), e.d);
      chk(e.name, "cycle_count", 32'(cycle_count), e.cnt);
      chk(e.name, "event_pc", event_pc, e.epc);
      chk(e.name, "bp_idx", 32'(bp_idx), e.idx);
    end
  end

  task automatic ex(input string n, input int v, input int d,
                    input int c, input logic [31:0] e,
                    input int i);
    q.push_back('{name: n, v: v, d: d, cnt: c, epc: e, idx: i});
  endtask

  task automatic tick(input logic v, input logic [31:0] rd,
                      input logic [31:0] p,
                      input logic clr = 1'b0,
                      input logic res = 1'b0);
    fif.i_valid = v;
    fif.i_read  = rd;
    fif.pc      = p;
    clear       = clr;
    resume      = res;
    @(posedge clk);
    #1;
    fif.i_valid = 1'b0;
    clear       = 1'b0;
    resume      = 1'b0;
  endtask

  task automatic restart(input string n);
    tick(1'b0, 32'h0, 32'h0, 1'b1);
    ex({n, "_clr"}, 0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 32'h0, 32'h0);
      ex({n, "_arm"}, 0, 0, 0, 32'h0, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    fif.i_valid = 1'b0;
    fif.i_read  = '0;
    fif.pc      = '0;
    bp_addr     = '0;
    bp_en       = '0;
    clear       = 1'b0;
    resume      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ex("reset", 0, 0, 0, 32'h0, 0);
    reset = 1'b1;

    // FAIL word fetched from the start: ignored while arming
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 32'h0, 32'h10);
      ex("arm_ign", 0, 0, 0, 32'h0, 0);
    end
    tick(1'b1, 32'h0, 32'h10);
    ex("fail1", 2, 1, 0, 32'h10, 0);
    tick(1'b1, 32'h1, 32'h14, 1'b0, 1'b1);
    ex("fail_sticky", 2, 1, 0, 32'h10, 0);

    // PASS at 0xA4 after three idle RUN cycles
    restart("pass");
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 32'h0, 32'h0);
      ex("pass_run", 0, 0, k, 32'h0, 0);
    end
    tick(1'b1, 32'h1, 32'hA4);
    ex("pass", 1, 1, 3, 32'hA4, 0);
    tick(1'b1, 32'h0, 32'hA8);
    ex("pass_sticky", 1, 1, 3, 32'hA4, 0);

    // TIMEOUT after exactly TO RUN cycles
    restart("tout");
    for (int k = 1; k < TO; k++) begin
      tick(1'b0, 32'h0, 32'h0);
      ex("tout_run", 0, 0, k, 32'h0, 0);
    end
    tick(1'b0, 32'h0, 32'h0);
    ex("tout", 3, 1, 9, 32'h0, 0);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    ex("tout_resume", 3, 1, 9, 32'h0, 0);
    tick(1'b0, 32'h0, 32'h0);
    ex("tout_hold", 3, 1, 9, 32'h0, 0);

    // FAIL vs breakpoint vs timeout on one fetch
    bp_addr = {32'h40, 32'h40};
    bp_en   = 2'b11;
    restart("prio");
    repeat (TO - 1) tick(1'b0, 32'h0, 32'h0);
    ex("prio_pre", 0, 0, 9, 32'h0, 0);
    tick(1'b1, 32'h0, 32'h40);
    ex("prio_fail", 2, 1, 9, 32'h40, 0);
    restart("prio_p");
    repeat (TO - 1) tick(1'b0, 32'h0, 32'h0);
    tick(1'b1, 32'h1, 32'h40);
    ex("prio_pass", 1, 1, 9, 32'h40, 0);
    restart("prio_c");
    repeat (TO - 1) tick(1'b0, 32'h0, 32'h0);
    tick(1'b1, 32'h0, 32'h40, 1'b1);
    ex("prio_clear", 0, 0, 0, 32'h0, 0);
    tick(1'b0, 32'h0, 32'h0);
    ex("prio_arm", 0, 0, 0, 32'h0, 0);

    // breakpoint, resume mask, re-hit
    restart("bp");
    tick(1'b0, 32'h0, 32'h0);
    tick(1'b0, 32'h0, 32'h0);
    ex("bp_pre", 0, 0, 2, 32'h0, 0);
    tick(1'b1, 32'h13, 32'h40);
    if (BP) ex("bp_hit", 4, 0, 2, 32'h40, 0);
    else    ex("bp_hit", 0, 0, 3, 32'h0, 0);
    tick(1'b0, 32'h0, 32'h0);
    if (BP) ex("bp_hold", 4, 0, 2, 32'h40, 0);
    else    ex("bp_hold", 0, 0, 4, 32'h0, 0);
    tick(1'b0, 32'h0, 32'h0);
    tick(1'b1, 32'h13, 32'h40, 1'b0, 1'b1);
    if (BP) ex("bp_resume", 0, 0, 2, 32'h40, 0);
    else    ex("bp_resume", 0, 0, 6, 32'h0, 0);
    tick(1'b1, 32'h13, 32'h40);
    if (BP) ex("bp_masked", 0, 0, 3, 32'h40, 0);
    else    ex("bp_masked", 0, 0, 7, 32'h0, 0);
    tick(1'b1, 32'h13, 32'h44);
    if (BP) ex("bp_move", 0, 0, 4, 32'h40, 0);
    else    ex("bp_move", 0, 0, 8, 32'h0, 0);
    tick(1'b1, 32'h13, 32'h40);
    if (BP) ex("bp_rehit", 4, 0, 4, 32'h40, 0);
    else    ex("bp_rehit", 0, 0, 9, 32'h0, 0);

    // second breakpoint only, then with it disabled
    bp_addr = {32'h40, 32'h80};
    restart("bp1");
    tick(1'b1, 32'h13, 32'h40);
    if (BP) ex("bp1_hit", 4, 0, 0, 32'h40, 1);
    else    ex("bp1_hit", 0, 0, 1, 32'h0, 0);
    bp_en = 2'b01;
    restart("bpdis");
    tick(1'b1, 32'h13, 32'h40);
    ex("bp_disabled", 0, 0, 1, 32'h0, 0);

    // async reset in RUN and in FAIL
    restart("rst_run");
    for (int k = 1; k <= 3; k++) tick(1'b0, 32'h0, 32'h0);
    ex("rst_pre", 0, 0, 3, 32'h0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    ex("rst_run", 0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    restart("rst_fail");
    tick(1'b0, 32'h0, 32'h0);
    tick(1'b1, 32'h0, 32'h5C);
    ex("rst_fail_pre", 2, 1, 1, 32'h5C, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    ex("rst_fail", 0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1'b0, 32'h0, 32'h0);
    ex("rst_arm", 0, 0, 0, 32'h0, 0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
